decoder_3to8: RTL and testbench
===============================

// Module: decoder_3to8
// PURPOSE
//   Registered 3-to-8 line decoder. Select bits {a,b,c} (a = MSB) choose one of eight
//   one-hot outputs d0..d7. Sits between control logic and per-line enables/strobes.
//   Outputs are registered so downstream logic sees glitch-free one-hot lines.
// PARAMETERS
//   none. Width is fixed at 3 select bits and 8 outputs.
// PORTS
//   clk  input   1  system clock; all state updates on the rising edge
//   rst  input   1  asynchronous, active-high reset
//   en   input   1  decode enable; 0 forces all outputs inactive on the next edge
//   a    input   1  select bit 2 (MSB)
//   b    input   1  select bit 1
//   c    input   1  select bit 0 (LSB)
//   d0   output  1  active when {a,b,c}=3'b000
//   d1   output  1  active when {a,b,c}=3'b001
//   d2   output  1  active when {a,b,c}=3'b010
//   d3   output  1  active when {a,b,c}=3'b011
//   d4   output  1  active when {a,b,c}=3'b100
//   d5   output  1  active when {a,b,c}=3'b101
//   d6   output  1  active when {a,b,c}=3'b110
//   d7   output  1  active when {a,b,c}=3'b111
//   One clock (clk); reset rst is asynchronous and active-high.
// BEHAVIOUR
//   - sel = {a,b,c}. The combinational one-hot word is hot[i] = en & (sel == i).
//   - Outputs are registered. Latency is 1 cycle: inputs sampled at edge N appear
//     on d0..d7 after edge N. No handshake.
//   - Reset: rst=1 drives all d0..d7 to the inactive level immediately, with no
//     clock needed. Outputs stay inactive while rst=1. The first decode happens on
//     the first rising edge after rst falls.
//   - When en=1, exactly one output is active on every cycle. When en=0, all
//     outputs are inactive. No other output pattern is ever produced.
//   - Select changes every cycle: each edge decodes the sel value present at that
//     edge. No hold or filtering.
//   - X/Z on a, b, c or en: no requirement on the outputs, except that reset
//     still forces the inactive level.
//   - rst asserted mid-operation overrides en and sel asynchronously.
// CONFIGURATION
//   - Macro DECODER_3TO8_ACTIVE_LOW_EN.
//   - Undefined (default): outputs are active-high. Active line = 1, the rest = 0,
//     reset value = 8'b0000_0000.
//   - Defined: every output is inverted. Active line = 0, the rest = 1, reset
//     value = 8'b1111_1111. The en=0 state is all outputs 1.
//   - Latency and select mapping are identical in both builds.
// STRUCTURE
//   - Package decoder_3to8_pkg:
//       SEL_W = 3, OUT_W = 8.
//       typedef logic [SEL_W-1:0] sel_t.
//       typedef logic [OUT_W-1:0] onehot_t.
//       Constant ONEHOT_IDLE = '0.
//   - Sub-module decoder_3to8_core: purely combinational (sel_t, en) -> onehot_t.
//   - Top level: the core, an output register with asynchronous reset, and the
//     optional inversion stage. The register word is split onto d0..d7.
// TESTING
//   - Reset: hold rst=1 for 3 cycles with random inputs -> d7..d0 = 8'h00
//     (8'hFF with the macro), including between edges.
//   - Sweep: en=1, step {a,b,c} through 000..111, one value per cycle -> one edge
//     later d7..d0 = 8'h01,02,04,08,10,20,40,80.
//   - Enable: en=0 with sel=3'b101 -> 8'h00. Raise en -> 8'h20 after the next
//     edge (1-cycle latency).
//   - Async reset mid-run: sel=3'b111, en=1, outputs 8'h80. Pulse rst between
//     edges -> 8'h00 at once. Release rst -> 8'h80 after the next edge.
//   - Random: 1000 cycles of random sel/en -> each cycle the outputs equal the
//     one-hot of the previous cycle's inputs, or zero when en=0.
//   - Active-low build: repeat the sweep -> 8'hFE,FD,FB,F7,EF,DF,BF,7F.

Source files
------------

// File: rtl/decoder_3to8_pkg.sv
// Shared types and constants for the registered 3-to-8 decoder.
// Output polarity follows macro DECODER_3TO8_ACTIVE_LOW_EN (defined = active-low).
package decoder_3to8_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] onehot_t;

    localparam onehot_t ONEHOT_IDLE = '0;

`ifdef DECODER_3TO8_ACTIVE_LOW_EN
    localparam onehot_t OUT_POL = '1;
`else
    localparam onehot_t OUT_POL = '0;
`endif

    function automatic onehot_t onehot_of(input sel_t sel);
        onehot_t v;
        v = ONEHOT_IDLE;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// Combinational select-to-one-hot decode, gated by enable.
// Always active-high; polarity is applied by the top level.
module decoder_3to8_core
    import decoder_3to8_pkg::*;
(
    input  sel_t    i_sel,
    input  logic    i_en,
    output onehot_t o_hot
);

    always_comb begin
        o_hot = ONEHOT_IDLE;
        if (i_en) begin
            o_hot = onehot_of(i_sel);
        end
    end

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 decoder: core decode, polarity stage, async-reset register.
// Macro DECODER_3TO8_ACTIVE_LOW_EN inverts every output, including the reset value.
module decoder_3to8
    import decoder_3to8_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic d4,
    output logic d5,
    output logic d6,
    output logic d7
);

    sel_t    w_sel;
    onehot_t w_hot;
    onehot_t w_next;
    onehot_t r_out;

    assign w_sel = {a, b, c};

    decoder_3to8_core u_core (
        .i_sel (w_sel),
        .i_en  (en),
        .o_hot (w_hot)
    );

    // Polarity applied before the flops so every output is driven straight from a register.
    assign w_next = w_hot ^ OUT_POL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= ONEHOT_IDLE ^ OUT_POL;
        end else begin
            r_out <= w_next;
        end
    end

    assign {d7, d6, d5, d4, d3, d2, d1, d0} = r_out;

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: vector table, scoreboard queue, async reset cases.
module tb_decoder_3to8;

`ifdef DECODER_3TO8_ACTIVE_LOW_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic a;
    logic b;
    logic c;
    logic d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0] w_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sbq[$];

    typedef struct {
        string      name;
        logic       en;
        logic [2:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[10];

    decoder_3to8 dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a),
        .b   (b),
        .c   (c),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .d4  (d4),
        .d5  (d5),
        .d6  (d6),
        .d7  (d7)
    );

    assign w_out = {d7, d6, d5, d4, d3, d2, d1, d0};

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic e, input logic [2:0] s);
        logic [7:0] v;
        v = 8'h00;
        if (e) begin
            case (s)
                3'd0: v = 8'h01;
                3'd1: v = 8'h02;
                3'd2: v = 8'h04;
                3'd3: v = 8'h08;
                3'd4: v = 8'h10;
                3'd5: v = 8'h20;
                3'd6: v = 8'h40;
                default: v = 8'h80;
            endcase
        end
        return v ^ INV;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic [2:0] s, input logic [7:0] exp);
        @(negedge clk);
        en = e;
        {a, b, c} = s;
        sbq.push_back(exp);
    endtask

    task automatic sample(input string nm);
        logic [7:0] exp;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h", nm, w_out);
        end else begin
            exp = sbq.pop_front();
            check(nm, w_out, exp);
        end
    endtask

    initial begin
        logic       re;
        logic [2:0] rs;

        tbl[0] = '{"sweep0",  1'b1, 3'd0, 8'h01 ^ INV};
        tbl[1] = '{"sweep1",  1'b1, 3'd1, 8'h02 ^ INV};
        tbl[2] = '{"sweep2",  1'b1, 3'd2, 8'h04 ^ INV};
        tbl[3] = '{"sweep3",  1'b1, 3'd3, 8'h08 ^ INV};
        tbl[4] = '{"sweep4",  1'b1, 3'd4, 8'h10 ^ INV};
        tbl[5] = '{"sweep5",  1'b1, 3'd5, 8'h20 ^ INV};
        tbl[6] = '{"sweep6",  1'b1, 3'd6, 8'h40 ^ INV};
        tbl[7] = '{"sweep7",  1'b1, 3'd7, 8'h80 ^ INV};
        tbl[8] = '{"en_off",  1'b0, 3'd5, 8'h00 ^ INV};
        tbl[9] = '{"en_on",   1'b1, 3'd5, 8'h20 ^ INV};

        rst = 1'b1;
        en  = 1'b1;
        {a, b, c} = 3'b000;
        #1;
        check("reset_t0", w_out, 8'h00 ^ INV);

        // Reset held across three edges with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'($urandom);
            {a, b, c} = 3'($urandom);
            #1;
            check("reset_mid", w_out, 8'h00 ^ INV);
            @(posedge clk);
            #1;
            check("reset_edge", w_out, 8'h00 ^ INV);
        end

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release", w_out, 8'h00 ^ INV);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].en, tbl[i].sel, tbl[i].exp);
            sample(tbl[i].name);
        end

        // Async reset between edges, then recovery.
        drive(1'b1, 3'd7, 8'h80 ^ INV);
        sample("pre_async");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", w_out, 8'h00 ^ INV);
        #1;
        rst = 1'b0;
        #1;
        check("async_hold", w_out, 8'h00 ^ INV);
        sbq.push_back(8'h80 ^ INV);
        sample("async_recover");

        for (int i = 0; i < 1000; i++) begin
            re = 1'($urandom);
            rs = 3'($urandom);
            drive(re, rs, model(re, rs));
            sample("random");
        end

        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain: %0d left, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
